// File: rtl/dmem_pkg.sv
// Shared types and decode helpers for the byte-lane data memory (dmem_bytelane).
package dmem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    localparam int LANES = 4;

    function automatic logic [3:0] lane_mask(size_e sz, logic [1:0] off);
        logic [3:0] m;
        case (sz)
            SZ_B, SZ_BU: m = 4'b0001 << off;
            SZ_H, SZ_HU: m = 4'b0011 << off;
            SZ_W:        m = 4'b1111;
            default:     m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic is_aligned(size_e sz, logic [1:0] off);
        logic ok;
        case (sz)
            SZ_B, SZ_BU: ok = 1'b1;
            SZ_H, SZ_HU: ok = ~off[0];
            SZ_W:        ok = (off == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Unsigned sizes exist only for loads.
    function automatic logic is_legal(logic [2:0] f3, logic we);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// DEPTH x 32 word array with per-byte write enables and a registered read port.
module dmem_lane_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [LANES-1:0]  we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [31:0]       wd,
    output logic [31:0]       rd
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rd_r;

    // Byte-lane writes; contents are intentionally not reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem_r[addr][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    // Synchronous read, captured only for accepted loads
    always_ff @(posedge clk) begin
        if (re) begin
            rd_r <= mem_r[addr];
        end
    end

    assign rd = rd_r;

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed data memory with RV32I load/store sizing and error flagging.
// Define DMEM_REG_OUT_EN to add an output register stage (latency 2 instead of 1).
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  REQ,
    input  logic                  WE,
    input  logic [2:0]            FUNCT3,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  RVALID,
    output logic                  ERR
);

    localparam int WORD_AW = $clog2(DEPTH);

    size_e                 sz_s;
    logic                  req_s;
    logic                  ok_s;
    logic                  rd_en_s;
    logic [LANES-1:0]      be_s;
    logic [DATA_WIDTH-1:0] wd_lane_s;
    logic [DATA_WIDTH-1:0] ram_rd_s;
    logic [DATA_WIDTH-1:0] shift_s;
    logic [DATA_WIDTH-1:0] ext_s;
    logic                  unused_addr_s;

    size_e      f3_r;
    logic [1:0] off_r;
    logic       vld_r;
    logic       err_r;
    logic       zero_r;

    // Address bits above the array wrap around and are deliberately ignored.
    assign unused_addr_s = ^A[ADDR_WIDTH-1:WORD_AW+2];

    assign sz_s    = size_e'(FUNCT3);
    assign req_s   = REQ & ~rst;
    assign ok_s    = is_legal(FUNCT3, WE) & is_aligned(sz_s, A[1:0]);
    assign rd_en_s = req_s & ~WE & ok_s;

    // Lane enables and store-data replication for accepted stores
    always_comb begin
        be_s      = 4'b0000;
        wd_lane_s = WD;
        if (req_s && WE && ok_s) begin
            be_s = lane_mask(sz_s, A[1:0]);
        end else begin
            be_s = 4'b0000;
        end
        case (sz_s)
            SZ_B, SZ_BU: wd_lane_s = {4{WD[7:0]}};
            SZ_H, SZ_HU: wd_lane_s = {2{WD[15:0]}};
            default:     wd_lane_s = WD;
        endcase
    end

    dmem_lane_ram #(
        .DEPTH (DEPTH),
        .AW    (WORD_AW)
    ) u_ram (
        .clk  (clk),
        .we   (be_s),
        .re   (rd_en_s),
        .addr (A[WORD_AW+1:2]),
        .wd   (wd_lane_s),
        .rd   (ram_rd_s)
    );

    // Stage register: zero_r forces RD to 0 after reset or a rejected access
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r  <= 1'b0;
            err_r  <= 1'b0;
            zero_r <= 1'b1;
            f3_r   <= SZ_B;
            off_r  <= 2'b00;
        end else begin
            vld_r <= REQ & ~WE;
            err_r <= REQ & ~ok_s;
            if (REQ && (!ok_s || !WE)) begin
                zero_r <= ~ok_s;
            end
            if (REQ && !WE && ok_s) begin
                f3_r  <= sz_s;
                off_r <= A[1:0];
            end
        end
    end

    // Bring the addressed byte/half down to bit 0 and extend it
    always_comb begin
        shift_s = ram_rd_s >> {off_r, 3'b000};
        ext_s   = ram_rd_s;
        if (zero_r) begin
            ext_s = 32'd0;
        end else begin
            case (f3_r)
                SZ_B:    ext_s = {{24{shift_s[7]}}, shift_s[7:0]};
                SZ_H:    ext_s = {{16{shift_s[15]}}, shift_s[15:0]};
                SZ_BU:   ext_s = {24'd0, shift_s[7:0]};
                SZ_HU:   ext_s = {16'd0, shift_s[15:0]};
                default: ext_s = ram_rd_s;
            endcase
        end
    end

`ifdef DMEM_REG_OUT_EN
    logic [DATA_WIDTH-1:0] rd_out_r;
    logic                  rvalid_out_r;
    logic                  err_out_r;

    // Second stage after extension
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_out_r     <= 32'd0;
            rvalid_out_r <= 1'b0;
            err_out_r    <= 1'b0;
        end else begin
            rd_out_r     <= ext_s;
            rvalid_out_r <= vld_r;
            err_out_r    <= err_r;
        end
    end

    assign RD     = rd_out_r;
    assign RVALID = rvalid_out_r;
    assign ERR    = err_out_r;
`else
    assign RD     = ext_s;
    assign RVALID = vld_r;
    assign ERR    = err_r;
`endif

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane: directed scenarios plus randomized traffic against a reference model.
module tb_dmem_bytelane;

`ifdef DMEM_REG_OUT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        REQ = 1'b0;
    logic        WE = 1'b0;
    logic [2:0]  FUNCT3 = 3'b000;
    logic [31:0] A = 32'd0;
    logic [31:0] WD = 32'd0;
    logic [31:0] RD;
    logic        RVALID;
    logic        ERR;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        rv;
        logic        er;
        logic        upd;
        logic [31:0] rd;
    } exp_t;

    logic [31:0] mem_m [int];

    dmem_bytelane dut (
        .clk(clk), .rst(rst), .REQ(REQ), .WE(WE), .FUNCT3(FUNCT3),
        .A(A), .WD(WD), .RD(RD), .RVALID(RVALID), .ERR(ERR)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic req, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        REQ = req; WE = we; FUNCT3 = f3; A = a; WD = wd;
        @(posedge clk); #1;
        REQ = 1'b0;
    endtask

    task automatic wait_lat();
        repeat (LAT-1) begin
            @(posedge clk); #1;
        end
    endtask

    // Reference: architectural effect of one request, straight from the ISA rules.
    function automatic exp_t model_access(logic req, logic we, logic [2:0] f3,
                                          logic [31:0] a, logic [31:0] wd);
        exp_t        e;
        int          idx, nb, off;
        logic [31:0] w, v;
        logic        legal;
        e = '0;
        if (!req) return e;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nb  = 1 << f3[1:0];
        off = int'(a[1:0]);
        idx = int'((a >> 2) % 32'd1024);
        if (!legal || (off % nb) != 0) begin
            e.rv = !we; e.er = 1'b1; e.upd = 1'b1; e.rd = 32'd0;
            return e;
        end
        w = mem_m.exists(idx) ? mem_m[idx] : 32'd0;
        if (we) begin
            for (int k = 0; k < nb; k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
            mem_m[idx] = w;
            return e;
        end
        v = w >> (8*off);
        if (nb == 1)
            v = (!f3[2] && v[7]) ? ((v & 32'hFF) | 32'hFFFF_FF00) : (v & 32'hFF);
        else if (nb == 2)
            v = (!f3[2] && v[15]) ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
        e.rv = 1'b1; e.upd = 1'b1; e.rd = v;
        return e;
    endfunction

    task automatic test_reset();
        repeat (2) begin @(posedge clk); #1; end
        n_cmp++;
        if ({RD, RVALID, ERR} !== 34'd0) begin
            n_bad++; $display("FAIL reset_state: rd=%h rv=%0b err=%0b, want 0/0/0", RD, RVALID, ERR);
        end
        rst = 1'b0;
        drive(1'b1, 1'b1, 3'b010, 32'h80, 32'h0);
        drive(1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 3'b010, 32'h80, 32'hFFFF_FFFF);
            n_cmp++;
            if ({RD, RVALID, ERR} !== 34'd0) begin
                n_bad++; $display("FAIL reset_inflight[%0d]: rd=%h rv=%0b err=%0b, want 0/0/0", i, RD, RVALID, ERR);
            end
        end
        rst = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
        wait_lat();
        n_cmp++;
        if ({RVALID, ERR, RD} !== {1'b1, 1'b0, 32'h0}) begin
            n_bad++; $display("FAIL reset_nowrite: rv=%0b err=%0b rd=%h, want 1/0/00000000", RVALID, ERR, RD);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        logic [31:0] as  [6] = '{32'h10, 32'h13, 32'h12, 32'h10, 32'h10, 32'h12};
        logic [31:0] exs [6] = '{32'hFFFF_FFA5, 32'h0000_0080, 32'hFFFF_8077,
                                 32'h0000_F0A5, 32'h8077_F0A5, 32'h0000_0077};
        drive(1'b1, 1'b1, 3'b010, 32'h10, 32'h8077_F0A5);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, f3s[i], as[i], 32'h0);
            wait_lat();
            n_cmp++;
            if ({RVALID, ERR, RD} !== {1'b1, 1'b0, exs[i]}) begin
                n_bad++; $display("FAIL load_ext[%0d]: rv=%0b err=%0b rd=%h, want 1/0/%h", i, RVALID, ERR, RD, exs[i]);
            end
        end
    endtask

    task automatic test_partial_store();
        drive(1'b1, 1'b1, 3'b010, 32'h20, 32'h0);
        drive(1'b1, 1'b1, 3'b000, 32'h21, 32'hFFFF_FF5A);
        wait_lat();
        n_cmp++;
        if ({RVALID, ERR} !== 2'b00) begin
            n_bad++; $display("FAIL store_no_rvalid: rv=%0b err=%0b, want 0/0", RVALID, ERR);
        end
        drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        wait_lat();
        n_cmp++;
        if ({RVALID, ERR, RD} !== {1'b1, 1'b0, 32'h0000_5A00}) begin
            n_bad++; $display("FAIL sb_lane: rv=%0b err=%0b rd=%h, want 1/0/00005a00", RVALID, ERR, RD);
        end
        drive(1'b1, 1'b1, 3'b001, 32'h22, 32'h0000_BEEF);
        drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        wait_lat();
        n_cmp++;
        if ({RVALID, ERR, RD} !== {1'b1, 1'b0, 32'hBEEF_5A00}) begin
            n_bad++; $display("FAIL sh_lane: rv=%0b err=%0b rd=%h, want 1/0/beef5a00", RVALID, ERR, RD);
        end
    endtask

    task automatic test_errors();
        logic        wes [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s [4] = '{3'b010, 3'b010, 3'b011, 3'b100};
        logic [31:0] as  [4] = '{32'h06, 32'h05, 32'h04, 32'h04};
        drive(1'b1, 1'b1, 3'b010, 32'h04, 32'hCAFE_F00D);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, wes[i], f3s[i], as[i], 32'h1111_1111);
            wait_lat();
            n_cmp++;
            if ({RVALID, ERR, RD} !== {~wes[i], 1'b1, 32'h0}) begin
                n_bad++; $display("FAIL err_case[%0d]: rv=%0b err=%0b rd=%h, want %0b/1/0", i, RVALID, ERR, RD, ~wes[i]);
            end
            @(posedge clk); #1;
            n_cmp++;
            if ({RVALID, ERR, RD} !== {1'b0, 1'b0, 32'h0}) begin
                n_bad++; $display("FAIL err_pulse[%0d]: rv=%0b err=%0b rd=%h, want 0/0/0", i, RVALID, ERR, RD);
            end
        end
        drive(1'b1, 1'b0, 3'b001, 32'h03, 32'h0);
        wait_lat();
        n_cmp++;
        if ({RVALID, ERR} !== 2'b11) begin
            n_bad++; $display("FAIL err_lh_odd: rv=%0b err=%0b, want 1/1", RVALID, ERR);
        end
        drive(1'b1, 1'b0, 3'b010, 32'h04, 32'h0);
        wait_lat();
        n_cmp++;
        if ({RVALID, ERR, RD} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            n_bad++; $display("FAIL err_nowrite: rv=%0b err=%0b rd=%h, want 1/0/cafef00d", RVALID, ERR, RD);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v [4];
        for (int i = 0; i < 4; i++) v[i] = $urandom;
        drive(1'b1, 1'b1, 3'b010, 32'h40, v[0]);
        drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        wait_lat();
        n_cmp++;
        if ({RVALID, ERR, RD} !== {1'b1, 1'b0, v[0]}) begin
            n_bad++; $display("FAIL st_then_ld: rv=%0b err=%0b rd=%h, want 1/0/%h", RVALID, ERR, RD, v[0]);
        end
        for (int i = 1; i < 4; i++) drive(1'b1, 1'b1, 3'b010, 32'h40 + 32'(4*i), v[i]);
        for (int i = 0; i < 3 + LAT; i++) begin
            drive(i < 4, 1'b0, 3'b010, 32'h40 + 32'(4*(i % 4)), 32'h0);
            if (i >= LAT-1) begin
                n_cmp++;
                if ({RVALID, ERR, RD} !== {1'b1, 1'b0, v[i-LAT+1]}) begin
                    n_bad++; $display("FAIL b2b_load[%0d]: rv=%0b err=%0b rd=%h, want 1/0/%h", i-LAT+1, RVALID, ERR, RD, v[i-LAT+1]);
                end
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({RVALID, ERR, RD} !== {1'b0, 1'b0, v[3]}) begin
            n_bad++; $display("FAIL b2b_idle: rv=%0b err=%0b rd=%h, want 0/0/%h", RVALID, ERR, RD, v[3]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] as [2] = '{32'h0, 32'hFFFF_F000};
        drive(1'b1, 1'b1, 3'b010, 32'h1000, 32'h1234_5678);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 3'b010, as[i], 32'h0);
            wait_lat();
            n_cmp++;
            if ({RVALID, ERR, RD} !== {1'b1, 1'b0, 32'h1234_5678}) begin
                n_bad++; $display("FAIL wrap[%0d]: rv=%0b err=%0b rd=%h, want 1/0/12345678", i, RVALID, ERR, RD);
            end
        end
    endtask

    task automatic test_random();
        exp_t        q [$];
        exp_t        e;
        logic [31:0] mrd = 32'd0;
        logic        mrd_ok = 1'b0;
        logic        req, we;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            void'(model_access(1'b1, 1'b1, 3'b010, 32'h200 + 32'(4*w), wd));
            drive(1'b1, 1'b1, 3'b010, 32'h200 + 32'(4*w), wd);
        end
        repeat (LAT) begin @(posedge clk); #1; end
        for (int n = 0; n < 300 + LAT - 1; n++) begin
            req = (n < 300) && ($urandom_range(0, 3) != 0);
            we  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            a   = 32'h200 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom);
            wd  = $urandom;
            q.push_back(model_access(req, we, f3, a, wd));
            drive(req, we, f3, a, wd);
            if (q.size() == LAT) begin
                e = q.pop_front();
                if (e.upd) begin mrd = e.rd; mrd_ok = 1'b1; end
                n_cmp++;
                if ({RVALID, ERR} !== {e.rv, e.er}) begin
                    n_bad++; $display("FAIL rand_flags[%0d]: rv=%0b err=%0b, want %0b/%0b", n, RVALID, ERR, e.rv, e.er);
                end
                if (mrd_ok) begin
                    n_cmp++;
                    if (RD !== mrd) begin
                        n_bad++; $display("FAIL rand_rd[%0d]: rd=%h, want %h", n, RD, mrd);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_partial_store();
        test_errors();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
